// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the request master: response codes and FSM states.
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RDATA
  } state_e;

endpackage

// File: rtl/axi_lite_vld_hold.sv
// VALID-until-handshake register: set by a one-cycle strobe, cleared on the
// edge where VALID and READY are both high.
module axi_lite_vld_hold (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic ready_i,
  output logic valid_o
);

  logic valid_q;

  // Hold VALID until the slave accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       valid_q <= 1'b0;
    else if (set_i)                valid_q <= 1'b1;
    else if (valid_q && ready_i)   valid_q <= 1'b0;
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/axi_lite_req_master.sv
// Single-outstanding AXI4-Lite master driven by a req/ready command port.
// Optional build macro AXI_LITE_RESP_CODE_EN adds the raw resp[1:0] output.
module axi_lite_req_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                resp_ok,
`ifdef AXI_LITE_RESP_CODE_EN
  output logic [1:0]          resp,
`endif
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                resp_ok_q;
  logic                ready_q;
  logic                take, aw_set, w_set, ar_set, b_hs, r_hs;
`ifdef AXI_LITE_RESP_CODE_EN
  logic [1:0]          resp_q;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, channel launch strobes and response-ready outputs.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    aw_set  = 1'b0;
    w_set   = 1'b0;
    ar_set  = 1'b0;
    b_hs    = 1'b0;
    r_hs    = 1'b0;
    BREADY  = 1'b0;
    RREADY  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          take = 1'b1;
          if (wr) begin
            aw_set  = 1'b1;
            w_set   = 1'b1;
            state_d = ST_WRITE;
          end else begin
            ar_set  = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        // A channel whose VALID already dropped has completed its handshake.
        if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          b_hs    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (ARREADY) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        RREADY = 1'b1;
        if (RVALID) begin
          r_hs    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  axi_lite_vld_hold u_aw (.clk(clk), .rst(rst), .set_i(aw_set), .ready_i(AWREADY), .valid_o(AWVALID));
  axi_lite_vld_hold u_w  (.clk(clk), .rst(rst), .set_i(w_set),  .ready_i(WREADY),  .valid_o(WVALID));
  axi_lite_vld_hold u_ar (.clk(clk), .rst(rst), .set_i(ar_set), .ready_i(ARREADY), .valid_o(ARVALID));

  // Command latch, completion capture and the one-cycle ready pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_ok_q <= 1'b0;
      ready_q   <= 1'b0;
`ifdef AXI_LITE_RESP_CODE_EN
      resp_q    <= OKAY;
`endif
    end else begin
      ready_q <= b_hs | r_hs;
      if (take) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (b_hs) begin
        resp_ok_q <= (BRESP == OKAY);
`ifdef AXI_LITE_RESP_CODE_EN
        resp_q    <= BRESP;
`endif
      end
      if (r_hs) begin
        rdata_q   <= RDATA;
        resp_ok_q <= (RRESP == OKAY);
`ifdef AXI_LITE_RESP_CODE_EN
        resp_q    <= RRESP;
`endif
      end
    end
  end

  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign rdata   = rdata_q;
  assign resp_ok = resp_ok_q;
  assign ready   = ready_q;
`ifdef AXI_LITE_RESP_CODE_EN
  assign resp    = resp_q;
`endif

endmodule

// File: tb/tb_axi_lite_req_master.sv
// Scoreboard bench for axi_lite_req_master with a configurable-latency slave.
module tb_axi_lite_req_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready, resp_ok;
`ifdef AXI_LITE_RESP_CODE_EN
  logic [1:0]  resp;
`endif
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
  logic        BVALID = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = '0;

  axi_lite_req_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .resp_ok(resp_ok),
`ifdef AXI_LITE_RESP_CODE_EN
    .resp(resp),
`endif
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          ok;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, ready_cnt = 0;

  // slave configuration
  int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0;
  logic [1:0] bresp_cfg = OKAY, rresp_cfg = OKAY;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Slave: sample handshakes on posedge, drive responses on negedge.
  always begin : slave
    int  aw_cnt, w_cnt, ar_cnt, b_cnt;
    bit  aw_got, w_got, ar_got, b_done, r_done;
    logic [31:0] mem;
    @(posedge clk);
    if (rst) begin
      aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0;
    end else begin
      if (AWVALID && AWREADY) aw_got = 1;
      if (WVALID && WREADY) begin w_got = 1; mem = WDATA; end
      if (ARVALID && ARREADY) ar_got = 1;
      if (BVALID && BREADY) b_done = 1;
      if (RVALID && RREADY) r_done = 1;
    end
    @(negedge clk);
    if (rst) begin
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0;
    end else begin
      if (AWVALID) begin AWREADY = (aw_cnt == aw_dly); aw_cnt++; end
      else begin AWREADY = 0; aw_cnt = 0; end
      if (WVALID) begin WREADY = (w_cnt == w_dly); w_cnt++; end
      else begin WREADY = 0; w_cnt = 0; end
      if (ARVALID) begin ARREADY = (ar_cnt == ar_dly); ar_cnt++; end
      else begin ARREADY = 0; ar_cnt = 0; end
      if (b_done) begin
        BVALID = 0; b_done = 0; aw_got = 0; w_got = 0; b_cnt = 0;
      end else if (aw_got && w_got && !BVALID) begin
        if (b_cnt == b_dly) begin BVALID = 1; BRESP = bresp_cfg; end
        else b_cnt++;
      end
      if (r_done) begin
        RVALID = 0; r_done = 0; ar_got = 0;
      end else if (ar_got && !RVALID) begin
        RVALID = 1; RDATA = mem; RRESP = rresp_cfg;
      end
    end
  end

  // Monitor: every ready pulse pops one expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ready) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_ready: got ready=1 expected no completion at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (e.rd) chk("rdata", 64'(rdata), 64'(e.rdata));
        chk("resp_ok", 64'(resp_ok), 64'(e.ok));
`ifdef AXI_LITE_RESP_CODE_EN
        chk("resp", 64'(resp), 64'(e.resp));
`endif
      end
    end
  end

  // mode 1: delayed-W timing checks (aw_dly=0, w_dly=3); poke>0: pulse req at that cycle
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] erd, input bit eok, input logic [1:0] ersp,
                      input int elat, input int mode, input int poke);
    int   start, lat;
    exp_t e;
    cyc();
    req = 1; wr = w; addr = a; wdata = d; wstrb = s;
    e.rd = !w; e.rdata = erd; e.ok = eok; e.resp = ersp;
    exp_q.push_back(e);
    start = ready_cnt;
    cyc();
    req = 0; lat = 1;
    if (w) begin
      chk("awvalid_rise", 64'(AWVALID), 64'd1);
      chk("wvalid_rise", 64'(WVALID), 64'd1);
      chk("awaddr", 64'(AWADDR), 64'(a));
      chk("wdata_out", 64'(WDATA), 64'(d));
      chk("wstrb_out", 64'(WSTRB), 64'(s));
    end else begin
      chk("arvalid_rise", 64'(ARVALID), 64'd1);
      chk("araddr", 64'(ARADDR), 64'(a));
    end
    while (ready_cnt == start && lat < 60) begin
      cyc();
      lat++;
      req = (lat == poke) ? 1'b1 : 1'b0;
      if (poke != 0 && lat == poke + 1) chk("no_extra_aw", 64'(AWVALID), 64'd0);
      if (mode == 0 && elat == 3 && lat == 2) begin
        if (w) begin
          chk("aw_dropped", 64'(AWVALID), 64'd0);
          chk("bready", 64'(BREADY), 64'd1);
        end else begin
          chk("ar_dropped", 64'(ARVALID), 64'd0);
          chk("rready", 64'(RREADY), 64'd1);
        end
      end
      if (mode == 1) begin
        if (lat == 2) begin
          chk("dly_aw_dropped", 64'(AWVALID), 64'd0);
          chk("dly_w_held", 64'(WVALID), 64'd1);
          chk("dly_bready_early", 64'(BREADY), 64'd0);
        end
        if (lat == 4) chk("dly_bready_wait", 64'(BREADY), 64'd0);
        if (lat == 5) chk("dly_bready_on", 64'(BREADY), 64'd1);
      end
    end
    req = 0;
    if (ready_cnt == start) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: got no ready expected completion at %0t", $time);
    end
    if (elat != 0) chk("latency", 64'(lat), 64'(elat));
    cyc();
    chk("single_ready", 64'(ready_cnt - start), 64'd1);
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, ready, resp_ok}), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_addr", 64'({AWADDR, ARADDR}), 64'd0);
    chk("reset_wdata", 64'({WDATA, WSTRB}), 64'd0);
    rst = 0;

    // zero-wait OKAY write then read back
    xact(1, 32'h10, 32'h0000_ABCD, 4'hF, 32'h0, 1, OKAY, 3, 0, 0);
    xact(0, 32'h10, 32'h0, 4'h0, 32'h0000_ABCD, 1, OKAY, 3, 0, 0);

    // W handshake lags AW by three cycles
    w_dly = 3;
    xact(1, 32'h24, 32'h1234_5678, 4'h3, 32'h0, 1, OKAY, 6, 1, 0);
    w_dly = 0;

    // SLVERR write, then OKAY read restores resp_ok, then DECERR read
    bresp_cfg = SLVERR;
    xact(1, 32'h30, 32'hDEAD_BEEF, 4'hC, 32'h0, 0, SLVERR, 3, 0, 0);
    bresp_cfg = OKAY;
    xact(0, 32'h30, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, OKAY, 3, 0, 0);
    rresp_cfg = DECERR;
    xact(0, 32'h34, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, DECERR, 3, 0, 0);
    rresp_cfg = OKAY;

    // req pulsed while waiting in WRESP is ignored
    b_dly = 2;
    xact(1, 32'h40, 32'h5555_AAAA, 4'hF, 32'h0, 1, OKAY, 5, 0, 2);
    b_dly = 0;

    // reset while ARVALID is held
    ar_dly = 5;
    cyc();
    req = 1; wr = 0; addr = 32'h50;
    cyc();
    req = 0;
    chk("abort_arvalid_pre", 64'(ARVALID), 64'd1);
    rst = 1;
    #1;
    chk("abort_arvalid", 64'(ARVALID), 64'd0);
    chk("abort_rready_ready", 64'({RREADY, ready}), 64'd0);
    chk("abort_rdata", 64'({rdata, 31'd0, resp_ok}), 64'd0);
    cyc(); cyc();
    rst = 0;
    ar_dly = 0;
    xact(0, 32'h50, 32'h0, 4'h0, 32'h5555_AAAA, 1, OKAY, 3, 0, 0);

    repeat (4) cyc();
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_lite_req_master.md
Name: axi_lite_req_master

Overview:
- Single-outstanding AXI4-Lite master that turns a simple request/ready command port into AXI4-Lite write (AW/W/B) or read (AR/R) transactions.
- Sits between a local controller (CPU-side FSM, test sequencer) and any AXI4-Lite slave such as a register file.
- Only one transaction is in flight at a time.

Parameters:
ADDR_W, 32, address width of addr/AWADDR/ARADDR
DATA_W, 32, data width of wdata/rdata/WDATA/RDATA; WSTRB width is DATA_W/8

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-high reset
req  in  1  command strobe; sampled only in IDLE
wr  in  1  1=write, 0=read; sampled with req
addr  in  ADDR_W  command address
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  write byte strobes
rdata  out  DATA_W  read data, valid when ready=1 for a read
ready  out  1  one-cycle completion pulse
resp_ok  out  1  1 when the completed response was OKAY (2'b00)
AWADDR  out  ADDR_W  write address
AWVALID  out  1  write address valid
AWREADY  in  1  write address ready
WDATA  out  DATA_W  write data
WSTRB  out  DATA_W/8  write strobes
WVALID  out  1  write data valid
WREADY  in  1  write data ready
BRESP  in  2  write response
BVALID  in  1  write response valid
BREADY  out  1  write response ready
ARADDR  out  ADDR_W  read address
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
RDATA  in  DATA_W  read data
RRESP  in  2  read response
RVALID  in  1  read valid
RREADY  out  1  read ready

Behaviour:
- Reset (async assert, sync release): state=IDLE. All VALID/READY outputs, ready and resp_ok are 0. rdata, AWADDR, ARADDR, WDATA and WSTRB are 0.
- States are IDLE, WRITE, WRESP, READ, RDATA.
- IDLE: on req=1 at a clock edge, latch addr, wdata, wstrb and wr.
  - Write: go to WRITE and assert AWVALID and WVALID together on the next cycle.
  - Read: go to READ and assert ARVALID.
- WRITE: AWVALID drops the cycle after the AWVALID&AWREADY handshake. WVALID drops independently after WVALID&WREADY. Both handshakes may occur in the same cycle or in either order. Once both are done, go to WRESP.
- WRESP: BREADY=1. On BVALID, capture resp_ok=(BRESP==2'b00), pulse ready for one cycle and return to IDLE.
- READ: ARVALID is held until ARREADY, then go to RDATA.
- RDATA: RREADY=1. On RVALID, capture rdata=RDATA and resp_ok=(RRESP==2'b00), pulse ready for one cycle and return to IDLE.
- A VALID, once asserted, is never deasserted before its handshake, and addr/data are held stable while VALID is high.
- req while not in IDLE is ignored (no queuing). req held high re-triggers a new transaction on the cycle after the ready pulse.
- rdata and resp_ok hold their values until the next completion.
- Latency with a zero-wait slave: write ready 3 cycles after req is sampled; read ready 3 cycles after req is sampled.
- Reset mid-transaction aborts immediately to IDLE with all outputs at reset values.

Optional Feature:
- Macro AXI_LITE_RESP_CODE_EN.
- Defined: adds output resp [1:0], holding the raw BRESP/RRESP captured at the last completion (reset 2'b00). SLVERR and DECERR then remain distinguishable.
- Undefined: port absent; only resp_ok is reported.

Decomposition:
- Package axi_lite_pkg holds:
  - resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - state enum typedef
- One natural sub-module, axi_lite_vld_hold: a single VALID-until-handshake register with reset. It is instantiated for AW, W and AR.

Test Plan:
- Write addr=0x10, wdata=0xABCD, wstrb=4'hF to a zero-wait OKAY slave -> AWVALID and WVALID rise together, one B handshake, ready pulses once, resp_ok=1, AWADDR=0x10, WDATA=0xABCD.
- Read addr=0x10 from a slave holding 0xABCD -> ARVALID then RREADY, ready pulse with rdata=0xABCD and resp_ok=1.
- WREADY delayed 3 cycles after AWREADY -> AWVALID drops after 1 cycle, WVALID held until its handshake, BREADY only after both handshakes, single ready pulse.
- Slave returns BRESP=2'b10 -> resp_ok=0 (and resp=2'b10 with AXI_LITE_RESP_CODE_EN); next OKAY read restores resp_ok=1.
- req pulsed while in WRESP -> ignored, no extra AWVALID, exactly one ready pulse.
- rst asserted while ARVALID=1 -> ARVALID, RREADY and ready go 0 immediately; a new read after release completes normally.
